// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: round-robin sequencer sharing one i2c_master between
// up to four requesters. Single-byte read/write commands come in over a
// valid/ready handshake, and each result returns as a one-cycle response pulse.
// Optional feature: define I2C_ARB_RETRY_EN to re-issue NACKed commands
// up to MAX_RETRY times before reporting the error.
module i2c_req_arbiter #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned BUSY_WAIT = 16,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [7*NUM_REQ-1:0]   req_addr_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_rw_i,
    output logic [NUM_REQ-1:0]     rsp_valid_o,
    output logic [7:0]             rsp_data_o,
    output logic                   rsp_err_o,
    output logic [1:0]             grant_id_o,
    output logic                   arb_busy_o,
    output logic                   m_start_o,
    output logic [6:0]             m_addr_o,
    output logic [7:0]             m_data_in_o,
    output logic                   m_rw_o,
    input  logic [7:0]             m_data_out_i,
    input  logic                   m_ack_error_i,
    input  logic                   m_busy_i
);

    // Reject illegal configurations at elaboration
    if (NUM_REQ < 2 || NUM_REQ > 4 || BUSY_WAIT < 2 || BUSY_WAIT > 255 || MAX_RETRY > 255) begin : g_bad_cfg
        $error("i2c_req_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_ISSUE,
        S_WAIT_DONE,
        S_RESPOND
`ifdef I2C_ARB_RETRY_EN
        , S_RETRY
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  wait_q;
    logic [1:0]  grant_q;
    logic [1:0]  last_q;
    logic [6:0]  m_addr_q;
    logic [7:0]  m_data_q;
    logic        m_rw_q;
    logic [7:0]  rsp_data_q;
    logic        rsp_err_q;
`ifdef I2C_ARB_RETRY_EN
    logic [7:0]  retry_q;
`endif

    logic        win_found;
    logic [1:0]  win_id;
    logic        hi_found;
    logic [1:0]  hi_id;
    logic [6:0]  win_addr;
    logic [7:0]  win_data;
    logic        win_rw;

    // Round-robin winner: first valid above last_q, else lowest valid index
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        hi_found  = 1'b0;
        hi_id     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_valid_i[i]) begin
                if (!win_found) begin
                    win_found = 1'b1;
                    win_id    = 2'(i);
                end
                if (!hi_found && i > 32'(last_q)) begin
                    hi_found = 1'b1;
                    hi_id    = 2'(i);
                end
            end
        end
        if (hi_found) begin
            win_id = hi_id;
        end
        win_addr = '0;
        win_data = '0;
        win_rw   = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (2'(i) == win_id) begin
                win_addr = req_addr_i[7*i +: 7];
                win_data = req_data_i[8*i +: 8];
                win_rw   = req_rw_i[i];
            end
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (|req_valid_i) state_d = S_GRANT;
            // A requester may withdraw between IDLE and GRANT; with nothing
            // left to grant, fall back to IDLE instead of issuing a ghost command.
            S_GRANT:     state_d = win_found ? S_ISSUE : S_IDLE;
            S_ISSUE: begin
                if (m_busy_i) begin
                    state_d = S_WAIT_DONE;
                end else if (wait_q == 8'(BUSY_WAIT - 1)) begin
                    state_d = S_RESPOND;
                end
            end
            S_WAIT_DONE: begin
                if (!m_busy_i) begin
`ifdef I2C_ARB_RETRY_EN
                    if (m_ack_error_i && retry_q < 8'(MAX_RETRY)) begin
                        state_d = S_RETRY;
                    end else begin
                        state_d = S_RESPOND;
                    end
`else
                    state_d = S_RESPOND;
`endif
                end
            end
`ifdef I2C_ARB_RETRY_EN
            S_RETRY:     state_d = S_ISSUE;
`endif
            S_RESPOND:   state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Output decode from current state
    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (state_q == S_GRANT && win_found && 2'(i) == win_id) begin
                req_ready_o[i] = 1'b1;
            end
            if (state_q == S_RESPOND && 2'(i) == grant_q) begin
                rsp_valid_o[i] = 1'b1;
            end
        end
        m_start_o   = (state_q == S_ISSUE);
        arb_busy_o  = (state_q != S_IDLE);
        rsp_data_o  = (state_q == S_RESPOND) ? rsp_data_q : '0;
        rsp_err_o   = (state_q == S_RESPOND) ? rsp_err_q : 1'b0;
        grant_id_o  = grant_q;
        m_addr_o    = m_addr_q;
        m_data_in_o = m_data_q;
        m_rw_o      = m_rw_q;
    end

    // Command capture, wait/retry counters and result sampling
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_q     <= '0;
            grant_q    <= 2'(NUM_REQ - 1);
            last_q     <= 2'(NUM_REQ - 1);
            m_addr_q   <= '0;
            m_data_q   <= '0;
            m_rw_q     <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
`ifdef I2C_ARB_RETRY_EN
            retry_q    <= '0;
`endif
        end else begin
            case (state_q)
                S_GRANT: begin
                    if (win_found) begin
                        grant_q  <= win_id;
                        m_addr_q <= win_addr;
                        m_data_q <= win_data;
                        m_rw_q   <= win_rw;
                    end
                    wait_q <= '0;
`ifdef I2C_ARB_RETRY_EN
                    retry_q <= '0;
`endif
                end
                S_ISSUE: begin
                    wait_q <= wait_q + 8'd1;
                    if (!m_busy_i && wait_q == 8'(BUSY_WAIT - 1)) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!m_busy_i) begin
                        rsp_err_q  <= m_ack_error_i;
                        rsp_data_q <= (m_rw_q && !m_ack_error_i) ? m_data_out_i : '0;
                    end
                end
`ifdef I2C_ARB_RETRY_EN
                S_RETRY: begin
                    retry_q <= retry_q + 8'd1;
                    wait_q  <= '0;
                end
`endif
                S_RESPOND: begin
                    last_q <= grant_q;
                end
                default: ;
            endcase
        end
    end

endmodule
